pc_fetch_stage: RTL

//   Instruction-fetch stage of the single-issue MIPS datapath. Holds the PC and fetches from

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/pc_target_calc.sv | 65 ++++++
 rtl/pc_fetch_stage.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the single-issue MIPS datapath front end:
//   datapath widths, the reset vector, the fetch-stage state encoding, the
//   next-PC source selector and a helper for sequential PC advance.
//   No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;
  localparam int JIDX_W  = 26;

  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

  // Fetch FSM: REQ keeps a request on the memory port, HOLD parks a word
  // that arrived while the decode-facing register was still occupied.
  typedef enum logic [0:0] {
    FS_REQ  = 1'b0,
    FS_HOLD = 1'b1
  } fetch_state_e;

  // Source of the next PC, in increasing priority order.
  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_BRANCH = 2'd1,
    SEL_JUMP   = 2'd2
  } pc_sel_e;

  // Sequential advance; wraps modulo 2^32 without any exception.
  function automatic logic [XLEN-1:0] pc_incr(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage : cpu_pkg

// File: rtl/pc_target_calc.sv
// -----------------------------------------------------------------------------
// pc_target_calc
//   Combinational next-PC logic. Computes the branch target
//   (id_pc_plus4 + word-aligned offset, wrapping mod 2^32), the J-type target
//   ({id_pc_plus4[31:28], index, 2'b00}) and the sequential pc+4, and applies
//   the priority jump > branch > pc+4.
// Ports
//   pc_i                 in   XLEN    current fetch PC
//   id_pc_plus4_i        in   XLEN    pc+4 of the redirecting instruction
//   branch_offset_sl2_i  in   XLEN    sign-extended immediate << 2
//   jump_index_i         in   JIDX_W  J-type instruction index
//   redirect_branch_i    in   1       taken branch this cycle
//   redirect_jump_i      in   1       jump this cycle
//   seq_pc_o             out  XLEN    pc_i + 4
//   redirect_tgt_o       out  XLEN    target of the winning redirect
//   next_pc_o            out  XLEN    prioritised next PC (jump > branch > seq)
//   redirect_o           out  1       any redirect this cycle
// -----------------------------------------------------------------------------
module pc_target_calc
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   id_pc_plus4_i,
  input  logic [XLEN-1:0]   branch_offset_sl2_i,
  input  logic [JIDX_W-1:0] jump_index_i,
  input  logic              redirect_branch_i,
  input  logic              redirect_jump_i,
  output logic [XLEN-1:0]   seq_pc_o,
  output logic [XLEN-1:0]   redirect_tgt_o,
  output logic [XLEN-1:0]   next_pc_o,
  output logic              redirect_o
);

  logic [XLEN-1:0] br_tgt;
  logic [XLEN-1:0] j_tgt;
  pc_sel_e         pc_sel;

  assign seq_pc_o   = pc_incr(pc_i);
  assign br_tgt     = id_pc_plus4_i + branch_offset_sl2_i;
  // Jumps stay inside the 256 MB region of the delay-slot-free pc+4.
  assign j_tgt      = {id_pc_plus4_i[XLEN-1:XLEN-4], jump_index_i, 2'b00};
  assign redirect_o = redirect_branch_i | redirect_jump_i;

  always_comb begin
    pc_sel = SEL_SEQ;
    if (redirect_jump_i) begin
      pc_sel = SEL_JUMP;
    end else if (redirect_branch_i) begin
      pc_sel = SEL_BRANCH;
    end
  end

  always_comb begin
    next_pc_o = seq_pc_o;
    case (pc_sel)
      SEL_JUMP:   next_pc_o = j_tgt;
      SEL_BRANCH: next_pc_o = br_tgt;
      default:    next_pc_o = seq_pc_o;
    endcase
  end

  // Only meaningful while redirect_o is high.
  assign redirect_tgt_o = redirect_jump_i ? j_tgt : br_tgt;

endmodule : pc_target_calc

// File: rtl/pc_fetch_stage.sv
// -----------------------------------------------------------------------------
// pc_fetch_stage
//   Instruction-fetch stage. Holds the PC, fetches over a req/ack handshake and
//   presents {instr, pc+4} to decode through a valid/ready register. Redirects
//   from decode (branch or jump, no delay slot) flush the presented instruction
//   and any word still in flight.
// Parameters
//   RESET_PC           PC loaded on reset; first fetch address
// Ports
//   clk                in   1   rising-edge clock
//   rst                in   1   asynchronous active-high reset
//   imem_req           out  1   fetch request, held until imem_ack
//   imem_addr          out  32  fetch address, stable while imem_req=1
//   imem_ack           in   1   request accepted, imem_rdata valid this cycle
//   imem_rdata         in   32  instruction word
//   if_valid           out  1   if_instr/if_pc_plus4 hold a live instruction
//   if_ready           in   1   decode consumes on valid&ready
//   if_instr           out  32  fetched instruction
//   if_pc_plus4        out  32  address of if_instr + 4
//   redirect_branch    in   1   taken branch (1-cycle pulse)
//   redirect_jump      in   1   jump (1-cycle pulse)
//   id_pc_plus4        in   32  pc+4 of the redirecting instruction
//   branch_offset_sl2  in   32  sign-extended immediate << 2
//   jump_index         in   26  J-type index
//   cur_pc             out  32  current PC register
// -----------------------------------------------------------------------------
module pc_fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_VECTOR
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [XLEN-1:0]     imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic                if_valid,
  input  logic                if_ready,
  output logic [INSTR_W-1:0]  if_instr,
  output logic [XLEN-1:0]     if_pc_plus4,
  input  logic                redirect_branch,
  input  logic                redirect_jump,
  input  logic [XLEN-1:0]     id_pc_plus4,
  input  logic [XLEN-1:0]     branch_offset_sl2,
  input  logic [JIDX_W-1:0]   jump_index,
  output logic [XLEN-1:0]     cur_pc
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  fetch_state_e        state_q, state_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic [XLEN-1:0]     pc_next_q, pc_next_d;    // target parked while killing
  logic                kill_q, kill_d;          // in-flight word is stale
  logic                req_en_q;                // gates req until first edge out of reset
  logic [INSTR_W-1:0]  hold_instr_q, hold_instr_d;
  logic [XLEN-1:0]     hold_pc4_q, hold_pc4_d;
  logic                out_valid_q, out_valid_d;
  logic [INSTR_W-1:0]  out_instr_q, out_instr_d;
  logic [XLEN-1:0]     out_pc4_q, out_pc4_d;

  // ---------------------------------------------------------------------------
  // Next-PC arithmetic
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] redirect_tgt;
  logic [XLEN-1:0] next_pc;
  logic            redirect;

  pc_target_calc u_pc_target_calc (
    .pc_i                (pc_q),
    .id_pc_plus4_i       (id_pc_plus4),
    .branch_offset_sl2_i (branch_offset_sl2),
    .jump_index_i        (jump_index),
    .redirect_branch_i   (redirect_branch),
    .redirect_jump_i     (redirect_jump),
    .seq_pc_o            (seq_pc),
    .redirect_tgt_o      (redirect_tgt),
    .next_pc_o           (next_pc),
    .redirect_o          (redirect)
  );

  // ---------------------------------------------------------------------------
  // Memory-side handshake (decoded, not registered)
  // ---------------------------------------------------------------------------
  logic fetch_req;
  logic ack_acc;
  logic out_free;

  assign fetch_req = (state_q == FS_REQ) && req_en_q;
  assign imem_req  = fetch_req;
  assign imem_addr = pc_q;
  // A stray ack while no request is outstanding is ignored.
  assign ack_acc   = fetch_req && imem_ack;
  // The output register can take a new word if it is empty or drains this edge.
  assign out_free  = !out_valid_q || if_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pc_next_d    = pc_next_q;
    kill_d       = kill_q;
    hold_instr_d = hold_instr_q;
    hold_pc4_d   = hold_pc4_q;
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_pc4_d    = out_pc4_q;

    if (out_valid_q && if_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      FS_REQ: begin
        if (!req_en_q) begin
          // Nothing is outstanding yet, so the PC can move directly.
          if (redirect) begin
            pc_d = redirect_tgt;
          end
        end else if (ack_acc) begin
          if (kill_q || redirect) begin
            // The returning word belongs to the wrong path: drop it and
            // restart at the newest known target.
            pc_d   = redirect ? redirect_tgt : pc_next_q;
            kill_d = 1'b0;
          end else if (out_free) begin
            out_valid_d = 1'b1;
            out_instr_d = imem_rdata;
            out_pc4_d   = seq_pc;
            pc_d        = next_pc;
          end else begin
            hold_instr_d = imem_rdata;
            hold_pc4_d   = seq_pc;
            pc_d         = next_pc;
            state_d      = FS_HOLD;
          end
        end else if (redirect) begin
          // Request still pending: the address must not move, so remember
          // the target and discard the word when it finally arrives.
          kill_d    = 1'b1;
          pc_next_d = redirect_tgt;
        end
      end

      FS_HOLD: begin
        if (redirect) begin
          pc_d    = next_pc;
          state_d = FS_REQ;
        end else if (if_ready) begin
          out_valid_d = 1'b1;
          out_instr_d = hold_instr_q;
          out_pc4_d   = hold_pc4_q;
          state_d     = FS_REQ;
        end
      end

      default: begin
        state_d = FS_REQ;
      end
    endcase

    // A redirect flushes whatever decode has not yet consumed.
    if (redirect) begin
      out_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FS_REQ;
      pc_q         <= RESET_PC;
      pc_next_q    <= RESET_PC;
      kill_q       <= 1'b0;
      req_en_q     <= 1'b0;
      hold_instr_q <= '0;
      hold_pc4_q   <= '0;
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_pc4_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pc_next_q    <= pc_next_d;
      kill_q       <= kill_d;
      req_en_q     <= 1'b1;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_pc4_q    <= out_pc4_d;
    end
  end

  assign if_valid    = out_valid_q;
  assign if_instr    = out_instr_q;
  assign if_pc_plus4 = out_pc4_q;
  assign cur_pc      = pc_q;

endmodule : pc_fetch_stage
